branch_issue_queue: RTL
=======================

Name: branch_issue_queue

Overview:
Parametrised, age-ordered branch reservation station for the out-of-order core. It holds renamed branch and jump ops until their source registers are calculated, then issues the oldest ready op to the branch unit through a valid/ready handshake. It supports enqueue backpressure, occupancy reporting, full flush, and selective squash of ops younger than a mispredicted branch. It sits between rename/dispatch and the branch resolution unit.

Parameters:
L, 8, queue depth (entries); power of two, ≥2
ROB_W, 5, ROB tag width
PC_W, `PC_SIZE, PC / target width
D_REGS, `NUM_D_REG, data physical registers; DW = $clog2(D_REGS)
S_REGS, `NUM_S_REG, status physical registers; SW = $clog2(S_REGS)

Ports:
clk  in  1  clock
n_rst  in  1  reset, synchronous, active-low
enq_valid  in  1  dispatch offers an op
enq_ready  out  1  queue accepts the op this cycle
enq_entry  in  bb_entry_t  {rob_addr, jump, predict_taken, pc, predict_target, rt_addr, rw_addr, rs_addr}
r_calculated_list  in  D_REGS x 1  data physical register calculated
s_calculated_list  in  S_REGS x 1  status physical register calculated
iss_valid  out  1  an op is presented
iss_ready  in  1  branch unit takes the op
iss_entry  out  bb_entry_t  issued op payload
flush_all  in  1  clear the whole queue
flush_valid  in  1  selective squash request
flush_rob_addr  in  ROB_W  tag of the mispredicted branch
rob_head  in  ROB_W  ROB tag of the oldest in-flight op
count  out  $clog2(L)+1  occupied entries

Behaviour:
- Storage is a collapsing queue. Valid entries occupy slots 0..count-1 in program order; slot 0 is the oldest.
- Reset: all slots invalid, count=0, iss_valid=0. enq_ready=1 in the first cycle after reset.
- Entry ready (combinational, every cycle) = valid & r_calculated_list[rt_addr] & (jump | s_calculated_list[rs_addr]). Readiness is re-evaluated each cycle and is never latched.
- Select: the lowest-index ready slot. iss_valid = any slot ready & ~flush_all & ~flush_valid. iss_entry shows the selected slot's payload.
- Issue: iss_valid & iss_ready removes the selected slot on the clock edge. Slots above it shift down by one.
- If iss_ready=0, the offered op may change next cycle when an older op becomes ready. No hold requirement.
- enq_ready = (count < L) & ~flush_all & ~flush_valid. No same-cycle bypass from an issue freeing a slot. A full queue stays unready for that cycle.
- Enqueue (enq_valid & enq_ready): the op is written to the tail slot. Tail = count, or count-1 if an issue fires in the same cycle. An enqueued op is issuable at the earliest in the following cycle (1-cycle min latency).
- Simultaneous issue and enqueue: both take effect; count is unchanged.
- flush_all: all slots are invalidated next edge and count=0. It has priority over everything.
- flush_valid: kill every slot with age(rob_addr) > age(flush_rob_addr), where age(x) = (x - rob_head) mod 2^ROB_W at ROB_W width. Killed slots always form a suffix. count becomes the number of survivors.
- During any flush cycle, no issue and no enqueue occur.
- count always equals the number of valid slots, with range 0..L.
- Reset mid-operation discards all contents the same way as flush_all.

Decomposition:
- Package branch_pkg holds:
  - bb_entry_t (packed struct with the payload fields above)
  - a rob_age function, (tag - head) at ROB_W
- Sub-module branch_select: an L-input lowest-index priority encoder that outputs found and idx. It is reused by future issue queues.

Test Plan:
- Reset, then enqueue 3 ops with sources uncalculated → count=3, iss_valid=0. Set r/s calculated for slot 1 only → iss_valid=1 with slot-1 payload. iss_ready=1 → count=2 next cycle; the former slot 2 is now in slot 1.
- Jump op with its rs source uncalculated and rt calculated → issues; a non-jump op with the same sources does not.
- Fill to L=8 → enq_ready=0. Issue and enqueue together at count=7 → count stays 7. The new op lands in slot 6.
- rob_head=30, entries with tags 30,31,0,1,2, flush_valid with flush_rob_addr=31 (wrap case) → tags 0,1,2 are killed. count=2, enq_ready=0 and iss_valid=0 during the flush cycle.
- flush_all while ops are ready and enq_valid=1 → nothing issues or enqueues, count=0 next cycle.
- Two ready ops, iss_ready held at 0 for 3 cycles → iss_entry stays on the oldest, count unchanged. Drop n_rst mid-run → count=0, iss_valid=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch issue path: the branch/jump op payload and
// ROB age arithmetic used to order ops relative to the current ROB head.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 64
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif

package branch_pkg;

  localparam int PC_W   = `PC_SIZE;
  localparam int D_REGS = `NUM_D_REG;
  localparam int S_REGS = `NUM_S_REG;

  localparam int ROB_W = 5;
  localparam int DW    = $clog2(D_REGS);
  localparam int SW    = $clog2(S_REGS);

  typedef struct packed {
    logic [ROB_W-1:0] rob_addr;
    logic             jump;
    logic             predict_taken;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  predict_target;
    logic [DW-1:0]    rt_addr;
    logic [DW-1:0]    rw_addr;
    logic [SW-1:0]    rs_addr;
  } bb_entry_t;

  // Distance from the ROB head, wrapping at ROB_W bits; larger means younger.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                               input logic [ROB_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/branch_issue_queue_if.sv
// Dispatch/issue/flush bundle of the branch issue queue. Handshakes: a
// transfer happens on a clock edge where valid and ready are both high.
interface branch_issue_queue_if
  import branch_pkg::*;
#(parameter int L = 8);
  localparam int CW = $clog2(L) + 1;

  logic              enq_valid;
  logic              enq_ready;
  bb_entry_t         enq_entry;
  logic [D_REGS-1:0] r_calculated_list;
  logic [S_REGS-1:0] s_calculated_list;
  logic              iss_valid;
  logic              iss_ready;
  bb_entry_t         iss_entry;
  logic              flush_all;
  logic              flush_valid;
  logic [ROB_W-1:0]  flush_rob_addr;
  logic [ROB_W-1:0]  rob_head;
  logic [CW-1:0]     count;

  modport master (
    output enq_valid, enq_entry, r_calculated_list, s_calculated_list,
           iss_ready, flush_all, flush_valid, flush_rob_addr, rob_head,
    input  enq_ready, iss_valid, iss_entry, count
  );

  modport slave (
    input  enq_valid, enq_entry, r_calculated_list, s_calculated_list,
           iss_ready, flush_all, flush_valid, flush_rob_addr, rob_head,
    output enq_ready, iss_valid, iss_entry, count
  );
endinterface

// File: rtl/branch_select.sv
// Lowest-index priority encoder: found is set when any request is high and
// idx names the lowest requesting position.
module branch_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/branch_issue_queue.sv
// Age-ordered collapsing reservation station for branch/jump ops: slot 0 is
// the oldest, the oldest source-ready op is offered to the branch unit.
module branch_issue_queue
  import branch_pkg::*;
#(
  parameter int L = 8
) (
  input logic clk,
  input logic n_rst,
  branch_issue_queue_if.slave bus
);
  localparam int CW = $clog2(L) + 1;
  localparam int IW = $clog2(L);

  bb_entry_t         slot_q [L];
  bb_entry_t         slot_d [L];
  logic [L-1:0]      valid_q, valid_d;
  logic [CW-1:0]     count_q, count_d;
  logic [L-1:0]      rdy, kill;
  logic [CW-1:0]     survivors, tail;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic              flushing, iss_fire, enq_fire;

  // Readiness is recomputed from the calculated lists every cycle.
  always_comb begin
    rdy  = '0;
    kill = '0;
    for (int i = 0; i < L; i++) begin
      rdy[i]  = valid_q[i] & bus.r_calculated_list[slot_q[i].rt_addr] &
                (slot_q[i].jump | bus.s_calculated_list[slot_q[i].rs_addr]);
      kill[i] = valid_q[i] &
                (rob_age(slot_q[i].rob_addr, bus.rob_head) >
                 rob_age(bus.flush_rob_addr, bus.rob_head));
    end
  end

  always_comb begin
    survivors = '0;
    for (int i = 0; i < L; i++)
      survivors = survivors + CW'(valid_q[i] & ~kill[i]);
  end

  branch_select #(.N(L)) u_select (
    .req   (rdy),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign flushing      = bus.flush_all | bus.flush_valid;
  assign bus.iss_valid = sel_found & ~flushing;
  assign bus.iss_entry = slot_q[sel_idx];
  assign bus.enq_ready = (count_q < CW'(L)) & ~flushing;
  assign bus.count     = count_q;
  assign iss_fire      = bus.iss_valid & bus.iss_ready;
  assign enq_fire      = bus.enq_valid & bus.enq_ready;
  assign tail          = count_q - CW'(iss_fire);

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (iss_fire) begin
      for (int i = 0; i < L - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          slot_d[i]  = slot_q[i+1];
          valid_d[i] = valid_q[i+1];
        end
      end
      valid_d[L-1] = 1'b0;
    end
    // Tail already accounts for a collapse happening on the same edge.
    if (enq_fire) begin
      slot_d[tail[IW-1:0]]  = bus.enq_entry;
      valid_d[tail[IW-1:0]] = 1'b1;
    end
    count_d = count_q + CW'(enq_fire) - CW'(iss_fire);
    if (bus.flush_all) begin
      valid_d = '0;
      count_d = '0;
    end else if (bus.flush_valid) begin
      valid_d = valid_q & ~kill;
      count_d = survivors;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end
endmodule
